// File: rtl/dram_block_master.sv
// Cache-side initiator for the ready/valid DRAM block interface: one block
// fill or writeback at a time, with beat counting and line (de)serialisation.
module dram_block_master #(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_SIZE = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_vld,
  output logic                             req_rdy,
  input  logic                             req_is_rd,
  input  logic [31:0]                      req_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] req_wr_line,
  output logic                             resp_vld,
  input  logic                             resp_rdy,
  output logic                             resp_is_rd,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] resp_rd_line,
  output logic                             dram_is_rd,
  output logic [31:0]                      dram_op_address,
  output logic                             cache_vld,
  input  logic                             dram_rdy,
  output logic [DATA_WIDTH-1:0]            dram_store,
  input  logic                             dram_vld,
  output logic                             cache_rdy,
  input  logic [DATA_WIDTH-1:0]            dram_load
);

  localparam int LINE_W = BLOCK_SIZE * DATA_WIDTH;
  localparam int IDX_W  = $clog2(BLOCK_SIZE);
  localparam int CNT_W  = IDX_W + 1;
  localparam logic [31:0]      ADDR_MASK = ~32'(BLOCK_SIZE - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BLOCK_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WDATA,
    RDATA,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_rd_q, is_rd_d;
  logic [31:0]         addr_q, addr_d;
  logic [LINE_W-1:0]   wr_line_q, wr_line_d;
  logic [LINE_W-1:0]   rd_line_q, rd_line_d;

  logic [IDX_W-1:0]    cnt_idx;
  logic                last_beat;

  assign cnt_idx   = cnt_q[IDX_W-1:0];
  assign last_beat = (cnt_q == LAST_CNT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_rd_d   = is_rd_q;
    addr_d    = addr_q;
    wr_line_d = wr_line_q;
    rd_line_d = rd_line_q;
    unique case (state_q)
      IDLE: begin
        if (req_vld) begin
          is_rd_d   = req_is_rd;
          addr_d    = req_addr & ADDR_MASK;
          wr_line_d = req_wr_line;
          cnt_d     = '0;
          state_d   = CMD;
        end
      end
      CMD: begin
        if (dram_rdy) begin
          state_d = is_rd_q ? RDATA : WDATA;
        end
      end
      WDATA: begin
        if (dram_rdy) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) begin
            state_d = RESP;
          end
        end
      end
      RDATA: begin
        if (dram_vld) begin
          rd_line_d[DATA_WIDTH*int'(cnt_idx) +: DATA_WIDTH] = dram_load;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (resp_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_rd_q   <= 1'b0;
      addr_q    <= '0;
      wr_line_q <= '0;
      rd_line_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_rd_q   <= is_rd_d;
      addr_q    <= addr_d;
      wr_line_q <= wr_line_d;
      rd_line_q <= rd_line_d;
    end
  end

  // Fill and writeback lines are separate so a writeback never disturbs the
  // last filled line presented on resp_rd_line.
  assign req_rdy         = (state_q == IDLE);
  assign cache_vld       = (state_q == CMD) || (state_q == WDATA);
  assign cache_rdy       = (state_q == RDATA);
  assign resp_vld        = (state_q == RESP);
  assign resp_is_rd      = is_rd_q;
  assign resp_rd_line    = rd_line_q;
  assign dram_is_rd      = is_rd_q;
  assign dram_op_address = addr_q;
  assign dram_store      = (state_q == WDATA) ?
                           wr_line_q[DATA_WIDTH*int'(cnt_idx) +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_dram_block_master.sv
// Scoreboard bench for dram_block_master: a DRAM responder model checks commands
// and write beats, a response monitor checks lines, latency and backpressure.
module tb_dram_block_master;

  localparam int DW = 8;
  localparam int BS = 32;
  localparam int LW = DW * BS;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_vld, req_rdy, req_is_rd;
  logic [31:0]   req_addr;
  logic [LW-1:0] req_wr_line;
  logic          resp_vld, resp_rdy, resp_is_rd;
  logic [LW-1:0] resp_rd_line;
  logic          dram_is_rd;
  logic [31:0]   dram_op_address;
  logic          cache_vld, dram_rdy;
  logic [DW-1:0] dram_store;
  logic          dram_vld, cache_rdy;
  logic [DW-1:0] dram_load;

  dram_block_master #(.DATA_WIDTH(DW), .BLOCK_SIZE(BS)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_is_rd(req_is_rd),
    .req_addr(req_addr), .req_wr_line(req_wr_line),
    .resp_vld(resp_vld), .resp_rdy(resp_rdy), .resp_is_rd(resp_is_rd),
    .resp_rd_line(resp_rd_line),
    .dram_is_rd(dram_is_rd), .dram_op_address(dram_op_address),
    .cache_vld(cache_vld), .dram_rdy(dram_rdy), .dram_store(dram_store),
    .dram_vld(dram_vld), .cache_rdy(cache_rdy), .dram_load(dram_load)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          is_rd;
    logic [31:0]   addr;
    logic [LW-1:0] line;
    int            lat;
    int            hold;
    int unsigned   t0;
  } txn_t;

  txn_t          cmd_q[$];
  txn_t          rsp_q[$];
  logic [LW-1:0] mem [logic [31:0]];

  int checks = 0;
  int errors = 0;

  int cmd_delay = 0;
  int rd_gap    = 0;
  bit stall_en  = 1'b0;
  bit stray     = 1'b0;
  int rphase    = 0;
  int rbeat     = 0;

  function automatic logic [LW-1:0] pat(input logic [7:0] b, input logic [7:0] s);
    logic [LW-1:0] l;
    l = '0;
    for (int i = 0; i < BS; i++) l[i*DW +: DW] = b + 8'(i) * s;
    return l;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // DRAM responder: accepts commands, consumes/produces beats, keeps memory.
  initial begin
    int            dly;
    int            gap;
    bit            prev_stall;
    logic [DW-1:0] prev_store;
    txn_t          cur;
    logic [LW-1:0] acc;
    dly = 0; gap = 0; prev_stall = 1'b0; prev_store = '0; acc = '0;
    cur = '{default: '0};
    dram_rdy = 1'b0; dram_vld = 1'b0; dram_load = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rphase = 0; dly = 0; prev_stall = 1'b0;
        dram_rdy = 1'b0; dram_vld = 1'b0;
        continue;
      end
      case (rphase)
        0: begin
          dram_rdy = 1'b0; dram_vld = 1'b0; dram_load = '0;
          if (cache_vld) begin
            if (dly < cmd_delay) begin
              dly++;
              if (stray) begin
                dram_vld  = 1'b1;
                dram_load = 8'hEE;
              end
            end else begin
              dram_rdy = 1'b1;
              dly = 0;
              if (cmd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL cmd_unexpected: got command at %0h expected none", dram_op_address);
              end else begin
                cur = cmd_q.pop_front();
                chk32("cmd_addr", dram_op_address, cur.addr);
                chk32("cmd_dir", 32'(dram_is_rd), 32'(cur.is_rd));
                rbeat = 0; gap = 0; prev_stall = 1'b0;
                acc = mem.exists(cur.addr) ? mem[cur.addr] : '0;
                rphase = cur.is_rd ? 2 : 1;
              end
            end
          end
        end
        1: begin
          dram_vld = 1'b0;
          if (prev_stall) chk32("wr_store_stable", 32'(dram_store), 32'(prev_store));
          chk32("wr_cache_vld", 32'(cache_vld), 32'd1);
          dram_rdy = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
          if (dram_rdy) begin
            chk32("wr_beat", 32'(dram_store), 32'(cur.line[rbeat*DW +: DW]));
            acc[rbeat*DW +: DW] = dram_store;
            rbeat++;
            prev_stall = 1'b0;
            if (rbeat == BS) begin
              mem[cur.addr] = acc;
              rphase = 0;
            end
          end else begin
            prev_stall = 1'b1;
            prev_store = dram_store;
          end
        end
        default: begin
          dram_rdy = stray;
          if (gap < rd_gap) begin
            gap++;
            dram_vld = 1'b0;
          end else begin
            dram_vld = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (dram_vld) begin
              dram_load = acc[rbeat*DW +: DW];
              rbeat++;
              if (rbeat == BS) rphase = 0;
            end else begin
              dram_load = 8'h5C;
            end
          end
        end
      endcase
    end
  end

  // Response monitor: pops the scoreboard on each response handshake.
  initial begin
    bit            seen;
    bit            chk_rdy_next;
    int            hold;
    logic [LW-1:0] snap;
    txn_t          e;
    seen = 1'b0; chk_rdy_next = 1'b0; hold = 0; snap = '0;
    e = '{default: '0};
    resp_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        seen = 1'b0; chk_rdy_next = 1'b0; hold = 0; resp_rdy = 1'b0;
        continue;
      end
      if (chk_rdy_next) begin
        chk32("req_rdy_after_resp", 32'(req_rdy), 32'd1);
        chk32("resp_vld_drop", 32'(resp_vld), 32'd0);
        chk_rdy_next = 1'b0;
      end
      resp_rdy = 1'b0;
      if (resp_vld) begin
        chk32("req_rdy_in_resp", 32'(req_rdy), 32'd0);
        if (!seen) begin
          if (rsp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL resp_spurious: got resp_vld=1 expected no response");
            resp_rdy = 1'b1;
            continue;
          end
          e = rsp_q[0];
          seen = 1'b1;
          hold = 0;
          snap = resp_rd_line;
          if (e.lat >= 0) chk32("resp_latency", cyc - e.t0, 32'(e.lat));
        end else begin
          chk("resp_line_stable", resp_rd_line, snap);
        end
        if (hold < e.hold) begin
          hold++;
        end else begin
          resp_rdy = 1'b1;
          chk32("resp_is_rd", 32'(resp_is_rd), 32'(e.is_rd));
          if (e.is_rd) chk("resp_rd_line", resp_rd_line, e.line);
          void'(rsp_q.pop_front());
          seen = 1'b0;
          chk_rdy_next = 1'b1;
        end
      end
    end
  end

  // For writes the line argument is the writeback data; for reads it is the expected fill.
  task automatic issue(input logic is_rd, input logic [31:0] addr, input logic [31:0] exp_addr,
                       input logic [LW-1:0] line, input int lat, input int hold);
    txn_t t;
    int   n;
    n = 0;
    @(negedge clk);
    while (!req_rdy) begin
      n++;
      if (n > 200) timeout_fail("req_rdy_wait");
      @(negedge clk);
    end
    req_vld     = 1'b1;
    req_is_rd   = is_rd;
    req_addr    = addr;
    req_wr_line = is_rd ? pat(8'hC3, 8'h05) : line;
    t.is_rd = is_rd; t.addr = exp_addr; t.line = line;
    t.lat = lat; t.hold = hold; t.t0 = cyc;
    cmd_q.push_back(t);
    rsp_q.push_back(t);
    @(negedge clk);
    req_is_rd   = ~is_rd;
    req_addr    = 32'hDEAD_BEEF;
    req_wr_line = ~line;
    @(negedge clk);
    req_vld = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (rsp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 3000) timeout_fail("txn_done");
    end
  endtask

  initial begin
    int n;
    rst = 1'b0;
    req_vld = 1'b0; req_is_rd = 1'b0; req_addr = '0; req_wr_line = '0;
    repeat (3) @(negedge clk);
    chk32("rst_req_rdy", 32'(req_rdy), 32'd1);
    chk32("rst_resp_vld", 32'(resp_vld), 32'd0);
    chk32("rst_cache_vld", 32'(cache_vld), 32'd0);
    chk32("rst_cache_rdy", 32'(cache_rdy), 32'd0);
    chk32("rst_dram_is_rd", 32'(dram_is_rd), 32'd0);
    chk32("rst_dram_addr", dram_op_address, 32'd0);
    chk32("rst_dram_store", 32'(dram_store), 32'd0);
    chk32("rst_resp_is_rd", 32'(resp_is_rd), 32'd0);
    chk("rst_resp_line", resp_rd_line, '0);
    rst = 1'b1;

    mem[32'h40] = pat(8'h10, 8'h01);
    mem[32'h20] = pat(8'hA0, 8'h01);

    // minimum-latency fill then writeback to an unaligned address
    issue(1'b1, 32'h47, 32'h40, pat(8'h10, 8'h01), BS + 2, 0);
    wait_done();
    issue(1'b0, 32'h47, 32'h40, pat(8'h00, 8'h01), BS + 2, 0);
    wait_done();
    chk("rd_line_held", resp_rd_line, pat(8'h10, 8'h01));

    // late command accept, first-beat gap, stray vld/rdy in the wrong phases
    cmd_delay = 3; rd_gap = 4; stray = 1'b1;
    issue(1'b1, 32'h20, 32'h20, pat(8'hA0, 8'h01), 41, 0);
    wait_done();
    cmd_delay = 0; rd_gap = 0; stray = 1'b0;

    // random beat stalls, then response backpressure on the read
    stall_en = 1'b1;
    issue(1'b0, 32'h100, 32'h100, pat(8'h33, 8'h07), -1, 0);
    wait_done();
    issue(1'b1, 32'h105, 32'h100, pat(8'h33, 8'h07), -1, 5);
    wait_done();
    stall_en = 1'b0;

    // reset mid-RDATA, then a clean fill
    issue(1'b1, 32'h20, 32'h20, pat(8'hA0, 8'h01), -1, 0);
    n = 0;
    while (!(rphase == 2 && rbeat >= 10)) begin
      @(negedge clk);
      n++;
      if (n > 200) timeout_fail("abort_wait");
    end
    rst = 1'b0;
    rsp_q.delete();
    cmd_q.delete();
    #1;
    chk32("abort_req_rdy", 32'(req_rdy), 32'd1);
    chk32("abort_resp_vld", 32'(resp_vld), 32'd0);
    chk32("abort_cache_vld", 32'(cache_vld), 32'd0);
    chk32("abort_cache_rdy", 32'(cache_rdy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    issue(1'b1, 32'h3A, 32'h20, pat(8'hA0, 8'h01), BS + 2, 0);
    wait_done();

    // write-then-read round trip through the responder memory
    issue(1'b0, 32'h00, 32'h00, pat(8'h5A, 8'h03), BS + 2, 0);
    wait_done();
    issue(1'b1, 32'h1F, 32'h00, pat(8'h5A, 8'h03), BS + 2, 0);
    wait_done();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    timeout_fail("global_watchdog");
  end

endmodule

// File: doc/dram_block_master.md
# dram_block_master

Cache-side initiator for the ready/valid DRAM block interface. It accepts one block request from the cache controller, which is either a line fill (read) or a writeback (write). It issues the command to the DRAM responder, streams `BLOCK_SIZE` data beats in the required direction, and returns a one-entry response holding the assembled line. It sits between the cache controller and the DRAM model and owns all beat counting and line (de)serialisation.

## Interface
- `DATA_WIDTH`, 8, width of one DRAM beat
- `BLOCK_SIZE`, 32, beats per block; power of two
- `clk`  input  1  clock; all logic on rising edge
- `rst`  input  1  reset, asynchronous and active-low
- `req_vld`  input  1  cache request valid
- `req_rdy`  output  1  request accepted when `req_vld && req_rdy`
- `req_is_rd`  input  1  1 = fill, 0 = writeback
- `req_addr`  input  32  block address; low `$clog2(BLOCK_SIZE)` bits ignored
- `req_wr_line`  input  `BLOCK_SIZE*DATA_WIDTH`  writeback line; beat i is `[i*DATA_WIDTH +: DATA_WIDTH]`
- `resp_vld`  output  1  response valid; held until `resp_rdy`
- `resp_rdy`  input  1  cache accepts response
- `resp_is_rd`  output  1  echo of the accepted `req_is_rd`
- `resp_rd_line`  output  `BLOCK_SIZE*DATA_WIDTH`  filled line; valid with `resp_vld` when `resp_is_rd`
- `dram_is_rd`  output  1  command direction toward DRAM
- `dram_op_address`  output  32  aligned block base address
- `cache_vld`  output  1  command valid in CMD; write-beat valid in WDATA
- `dram_rdy`  input  1  DRAM accepts the command or write beat
- `dram_store`  output  `DATA_WIDTH`  write beat data
- `dram_vld`  input  1  DRAM read beat valid
- `cache_rdy`  output  1  master accepts read beat
- `dram_load`  input  `DATA_WIDTH`  read beat data

## Operation
- States are IDLE, CMD, WDATA, RDATA and RESP.
- **IDLE**
  - `req_rdy`=1.
  - On accept, the block registers `req_is_rd`, the aligned address (`req_addr & ~(BLOCK_SIZE-1)`) and `req_wr_line`.
  - It clears the beat counter and goes to CMD.
- **CMD**
  - `cache_vld`=1, `dram_is_rd`=registered direction, `dram_op_address`=registered address.
  - On `dram_rdy`, the block goes to RDATA if the request is a read, otherwise WDATA.
- **WDATA**
  - `cache_vld`=1 and `dram_store`=line beat[cnt].
  - Each cycle with `dram_rdy`=1 increments cnt.
  - After beat `BLOCK_SIZE-1` transfers, the block goes to RESP.
- **RDATA**
  - `cache_rdy`=1.
  - Each cycle with `dram_vld`=1 writes `dram_load` into line beat[cnt] and increments cnt.
  - After beat `BLOCK_SIZE-1`, the block goes to RESP.
- **RESP**
  - `resp_vld`=1.
  - On `resp_rdy`, the block goes to IDLE.
  - `resp_rd_line` holds its value until the next read's RDATA overwrites it.
- Beat counter is `$clog2(BLOCK_SIZE)+1` bits; it never wraps during a transaction.
- `dram_vld` outside RDATA is ignored; `dram_rdy` outside CMD/WDATA is ignored.
- `req_vld` outside IDLE is not accepted; exactly one transaction is outstanding at a time.
- Changes on `req_*` after acceptance have no effect.
- The DRAM command-to-first-beat latency is arbitrary. The master waits indefinitely, with no timeout.

## Timing
- **Reset**
  - State=IDLE, cnt=0, line buffer=0.
  - `req_rdy`=1 and all other outputs are 0: `resp_vld`, `cache_vld`, `cache_rdy`, `dram_is_rd`, `dram_op_address`, `dram_store`, `resp_rd_line`, `resp_is_rd`.
- Reset asserted mid-transaction aborts immediately to IDLE. No partial response is issued.
- All outputs are registered-state decodes with no combinational path from `req_*`/`resp_rdy` to `req_rdy`. One exception: `dram_store` is a mux of the line buffer by cnt.
- **Accept to command:** `cache_vld` rises the cycle after acceptance.
- **Minimum write transaction:** accept (cycle 0) → CMD (1) → WDATA beats 2..`BLOCK_SIZE+1` → `resp_vld` at `BLOCK_SIZE+2`, with `dram_rdy` constantly 1.
- **Minimum read:** same timing with `dram_vld` constantly 1 from cycle 2.
- Stalled beats (`dram_rdy`/`dram_vld`=0) hold cnt and data. `dram_store` stays stable while `cache_vld && !dram_rdy`.
- RESP→IDLE takes 1 cycle. A new request can be accepted the cycle after `resp_vld && resp_rdy`, not in the same cycle.

## Test plan
- **Reset values:** assert `rst`=0 mid-RDATA at beat 10 → next cycle state IDLE, `req_rdy`=1, `resp_vld`=0, `cache_vld`=0; a following read completes normally with a fresh count.
- **Back-to-back writeback:** read `req_addr`=0x47 with `req_wr_line` beat i = i, then write and `dram_rdy`=1 constantly.
  - `dram_op_address`=0x40 in CMD.
  - Beats 0..31 appear on consecutive cycles.
  - `resp_vld` arrives at cycle 34 with `resp_is_rd`=0.
- **Fill with latency:** read to 0x20; DRAM asserts `dram_rdy` 3 cycles late, then `dram_vld` with data 0xA0+i after a 4-cycle gap → `resp_rd_line` beat i = 0xA0+i, `resp_is_rd`=1.
- **Beat stalls:**
  - Random `dram_vld`/`dram_rdy` gaps (≈50%) → exactly 32 transfers, correct order, `dram_store` stable while stalled.
  - Stray `dram_vld` in CMD is ignored.
- **Response backpressure:** hold `resp_rdy`=0 for 5 cycles → `resp_vld` and `resp_rd_line` stay stable and `req_rdy`=0; after the handshake, `req_rdy`=1 the next cycle.
- **Write-then-read round trip:** against the DRAM responder, write a pattern to 0x00 then read 0x00 → identical line.
